// File: rtl/cpu_timing_pkg.sv
// Shared types for the beat/phase timing generator and its neighbours.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cpu_timing_pkg;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        PH_T1 = 2'd1,
        PH_T2 = 2'd2,
        PH_T3 = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        BEAT_W1 = 3'b001,
        BEAT_W2 = 3'b010,
        BEAT_W3 = 3'b100
    } beat_t;

    localparam int PHASE_CNT_W = 4;

    // Beat chosen at the end of T3; only the controller input relevant to the
    // current beat is consulted, so short/long may both be high safely.
    function automatic beat_t next_beat(input beat_t cur, input logic short_sel, input logic long_sel);
        beat_t nb;
        case (cur)
            BEAT_W1: nb = short_sel ? BEAT_W1 : BEAT_W2;
            BEAT_W2: nb = long_sel  ? BEAT_W3 : BEAT_W1;
            default: nb = BEAT_W1;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/timing_gen_qd_sync.sv
// Start button conditioning: 2-flop synchronizer, optional debounce (TIMING_GEN_DEBOUNCE_EN), rising-edge pulse.
// Latency: qd_rise appears 2 clk after qd is sampled high (plus DEBOUNCE_CYCLES with the filter compiled in).
// Backpressure: none; qd_rise is a single-cycle pulse the consumer must take or lose.
module qd_sync #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic qd,
    output logic qd_rise
);

    logic sync_q1;
    logic sync_q2;
    logic level;
    logic level_d;

    // Two-stage synchronizer for the asynchronous push-button level.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= qd;
            sync_q2 <= sync_q1;
        end
    end

`ifdef TIMING_GEN_DEBOUNCE_EN
    localparam int DB_CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic                db_level;
    logic [DB_CNT_W-1:0] db_cnt;

    // Filtered level follows the synchronized input only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (sync_q2 == db_level) begin
            db_cnt   <= '0;
        end else if (db_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level <= sync_q2;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + 1'b1;
        end
    end

    assign level = db_level;
`else
    assign level = sync_q2;

    // The debounce length only matters when the filter is compiled in.
    if (DEBOUNCE_CYCLES < 2) begin : g_debounce_len_unused
    end
`endif

    // Previous level for the rising-edge detector.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign qd_rise = level & ~level_d;

endmodule

// File: rtl/timing_gen.sv
// Beat/phase timing generator feeding the hardwired controller (optional qd debounce: TIMING_GEN_DEBOUNCE_EN).
// Latency: T1 starts 3 clk after qd is sampled high; each phase lasts PHASE_CYCLES clk; beat updates on the edge leaving T3.
// Backpressure: none; stop halts after the current beat, restart only via a fresh qd rise.
module timing_gen
    import cpu_timing_pkg::*;
#(
    parameter int PHASE_CYCLES    = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic qd,
    input  logic short,
    input  logic long,
    input  logic stop,
    output logic t1,
    output logic t2,
    output logic t3,
    output logic w1,
    output logic w2,
    output logic w3,
    output logic running
);

    phase_t                 state_q, state_d;
    beat_t                  beat_q, beat_d;
    logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;
    logic                   qd_rise;
    logic                   phase_last;

    qd_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_qd_sync (
        .clk     (clk),
        .clr     (clr),
        .qd      (qd),
        .qd_rise (qd_rise)
    );

    assign phase_last = (cnt_q == PHASE_CNT_W'(PHASE_CYCLES - 1));

    // Next phase, next beat and phase-counter value; counter restarts on every phase change.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            HALT: begin
                cnt_d = '0;
                if (qd_rise) begin
                    state_d = PH_T1;
                end
            end
            PH_T1: begin
                if (phase_last) begin
                    state_d = PH_T2;
                    cnt_d   = '0;
                end
            end
            PH_T2: begin
                if (phase_last) begin
                    state_d = PH_T3;
                    cnt_d   = '0;
                end
            end
            PH_T3: begin
                if (phase_last) begin
                    // Beat advances even when halting so a restart resumes at the right beat.
                    beat_d  = next_beat(beat_q, short, long);
                    state_d = stop ? HALT : PH_T1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = HALT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, beat and counter registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= HALT;
            beat_q  <= BEAT_W1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Phase strobes and running are flops loaded from the next-state decode,
    // so the controller never sees decode glitches.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            t1      <= 1'b0;
            t2      <= 1'b0;
            t3      <= 1'b0;
            running <= 1'b0;
        end else begin
            t1      <= (state_d == PH_T1);
            t2      <= (state_d == PH_T2);
            t3      <= (state_d == PH_T3);
            running <= (state_d != HALT);
        end
    end

    assign w1 = beat_q[0];
    assign w2 = beat_q[1];
    assign w3 = beat_q[2];

endmodule

// File: tb/tb_timing_gen.sv
module tb_timing_gen;

    localparam int P  = 2;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic qd = 1'b0, short = 1'b0, long = 1'b0, stop = 1'b0;
    logic t1, t2, t3, w1, w2, w3, running;

    int n_cmp = 0;
    int n_err = 0;

    timing_gen #(.PHASE_CYCLES(P), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .clr(clr), .qd(qd), .short(short), .long(long), .stop(stop),
        .t1(t1), .t2(t2), .t3(t3), .w1(w1), .w2(w2), .w3(w3), .running(running)
    );

    always #5 clk = ~clk;

    // Reference model: beat as 1..3, phase as 0 (halted) or 1..3,
    // elapsed cycles within the phase, and a history of sampled qd values.
    int m_beat = 1;
    int m_phase = 0;
    int m_elapsed = 0;
    bit h0 = 0, h1 = 0, h2 = 0;
    bit f_lvl = 0, f_prev = 0;
    int f_cnt = 0;

    always @(posedge clk or negedge clr) begin
        bit rise;
        if (!clr) begin
            m_beat = 1; m_phase = 0; m_elapsed = 0;
            h0 = 0; h1 = 0; h2 = 0;
            f_lvl = 0; f_prev = 0; f_cnt = 0;
        end else begin
`ifdef TIMING_GEN_DEBOUNCE_EN
            // Synchronized level seen this edge is the qd sampled two edges ago.
            rise = f_lvl & ~f_prev;
            f_prev = f_lvl;
            if (h1 == f_lvl) f_cnt = 0;
            else if (f_cnt == DB - 1) begin f_lvl = h1; f_cnt = 0; end
            else f_cnt++;
`else
            // Rise seen this edge: qd high two edges ago and low three edges ago.
            rise = h1 & ~h2;
`endif
            h2 = h1; h1 = h0; h0 = qd;
            if (m_phase == 0) begin
                if (rise) begin m_phase = 1; m_elapsed = 0; end
            end else if (m_elapsed < P - 1) begin
                m_elapsed++;
            end else if (m_phase < 3) begin
                m_phase++; m_elapsed = 0;
            end else begin
                if (m_beat == 1) m_beat = short ? 1 : 2;
                else if (m_beat == 2) m_beat = long ? 3 : 1;
                else m_beat = 1;
                m_phase = stop ? 0 : 1;
                m_elapsed = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("t1", 32'(t1), 32'(m_phase == 1));
        check("t2", 32'(t2), 32'(m_phase == 2));
        check("t3", 32'(t3), 32'(m_phase == 3));
        check("w1", 32'(w1), 32'(m_beat == 1));
        check("w2", 32'(w2), 32'(m_beat == 2));
        check("w3", 32'(w3), 32'(m_beat == 3));
        check("running", 32'(running), 32'(m_phase != 0));
        check("inv_w_onehot", 32'(int'(w1) + int'(w2) + int'(w3)), 32'd1);
        check("inv_t_atmost1", 32'((int'(t1) + int'(t2) + int'(t3)) <= 1), 32'd1);
        check("inv_run_eq_t", 32'(running), 32'(t1 | t2 | t3));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic qd_press(input int len);
        qd = 1'b1;
        repeat (len) step();
        qd = 1'b0;
    endtask

    initial begin
        int starts;
        bit was_run;
        bit hit;
        #3 clr = 1'b0;
        repeat (3) step();
        check("rst_running", 32'(running), 32'd0);
        check("rst_w1", 32'(w1), 32'd1);
        clr = 1'b1;

        // Short loop in W1.
        short = 1'b1;
        qd_press(3);
        repeat (25) step();
        check("short_w1_hold", 32'(w1), 32'd1);

        // W1,W2 alternation, then long in W2 (long in W1 has no effect).
        short = 1'b0;
        repeat (30) step();
        long = 1'b1;
        repeat (30) step();

        // Stop at end of a W1 beat with short=0.
        long = 1'b0;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            hit = (m_beat == 1 && m_phase == 3);
        end
        check("reach_w1_t3", 32'(hit), 32'd1);
        stop = 1'b1;
        repeat (2 * P + 2) step();
        check("halt_running", 32'(running), 32'd0);
        check("halt_w2", 32'(w2), 32'd1);
        stop = 1'b0;
        repeat (5) step();
        qd_press(2);
        repeat (6) step();
        qd_press(2);
        repeat (10) step();

        // Async clear in T2 of W3.
        long = 1'b1;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            hit = (m_beat == 3 && m_phase == 2);
        end
        check("reach_w3_t2", 32'(hit), 32'd1);
        #2 clr = 1'b0;
        #1;
        check_all();
        check("clr_running", 32'(running), 32'd0);
        check("clr_w1", 32'(w1), 32'd1);
        step();
        clr = 1'b1;
        repeat (15) step();
        check("clr_no_restart", 32'(running), 32'd0);

`ifdef TIMING_GEN_DEBOUNCE_EN
        // Glitch shorter than the filter, then a solid press with stop held.
        stop = 1'b1;
        qd_press(5);
        repeat (40) step();
        check("glitch_nostart", 32'(running), 32'd0);
        starts = 0;
        was_run = 0;
        qd = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (i == 20) qd = 1'b0;
            step();
            if (running && !was_run) starts++;
            was_run = running;
        end
        check("press_one_start", 32'(starts), 32'd1);
        stop = 1'b0;
`else
        starts = 0;
        was_run = 0;
`endif

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 7) == 0) qd = ~qd;
            short = 1'($urandom);
            long  = 1'($urandom);
            stop  = ($urandom_range(0, 5) == 0);
            clr   = ($urandom_range(0, 299) != 0);
        end
        clr = 1'b1;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
